// File: rtl/multicycle_cpu_if.sv
// Instruction-memory fetch port of the multicycle CPU.
//   req   : fetch request, held by the CPU until ack
//   addr  : byte address of the instruction, stable while req=1
//   ack   : rdata is valid this cycle (ignored while req=0)
//   rdata : 16-bit instruction word
// The CPU is the master; the instruction memory is the slave.
interface multicycle_cpu_if #(
  parameter int PC_W = 16
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [15:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle 16-bit-ISA CPU core with four DATA_W-bit registers.
// Each instruction runs through FETCH -> DECODE -> EXECUTE -> WRITEBACK;
// the fetch stretches over memory wait states, and the halt word parks the
// core in a sticky HALT state until reset.
// Ports:
//   clock    : single clock, all state on posedge
//   resetn   : asynchronous active-low reset
//   imem     : instruction fetch port (master side of multicycle_cpu_if)
//   pc       : architectural PC (byte address, instructions are 2 bytes)
//   ir       : current instruction register
//   alu_out  : ALU result latched in EXECUTE
//   state    : FETCH=0 DECODE=1 EXECUTE=2 WRITEBACK=3 HALT=4
//   retire   : one-cycle pulse in WRITEBACK
//   halted   : 1 while in HALT
module multicycle_cpu #(
  parameter int              DATA_W    = 16,
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     HALT_WORD = 16'hFFFF
) (
  input  logic              clock,
  input  logic              resetn,
  multicycle_cpu_if.master  imem,
  output logic [PC_W-1:0]   pc,
  output logic [15:0]       ir,
  output logic [DATA_W-1:0] alu_out,
  output logic [2:0]        state,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  state_t state_reg, state_next;
  logic   req_reg, req_next;

  logic [PC_W-1:0]   pc_reg;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] a_reg, b_reg, alu_reg;
  logic              taken_reg;
  logic [DATA_W-1:0] regs [4];

  // Instruction fields
  logic [3:0] op;
  logic [1:0] rs, rt, rd, dest;
  assign op = ir_reg[15:12];
  assign rs = ir_reg[11:10];
  assign rt = ir_reg[9:8];
  assign rd = ir_reg[7:6];

  logic is_addi, is_beq, is_bne, writes_reg;
  assign is_addi    = (op == 4'd7);
  assign is_beq     = (op == 4'd10);
  assign is_bne     = (op == 4'd11);
  assign writes_reg = (op <= 4'd7);
  assign dest       = is_addi ? rt : rd;

  // Sign-extended immediate for the ALU, and the branch offset in bytes
  // (immediate counts instructions, hence the extra shift).
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   br_off, pc_plus2, br_target;
  assign imm_d     = {{(DATA_W-8){ir_reg[7]}}, ir_reg[7:0]};
  assign br_off    = {{(PC_W-9){ir_reg[7]}}, ir_reg[7:0], 1'b0};
  assign pc_plus2  = pc_reg + PC_W'(2);
  assign br_target = pc_plus2 + br_off;

  // ALU
  logic [DATA_W-1:0] alu_b, diff, alu_res;
  logic              lt, taken;
  assign alu_b = is_addi ? imm_d : b_reg;
  assign diff  = a_reg + ~alu_b + DATA_W'(1);
  // Signed less-than from the subtraction: when signs differ the
  // subtraction may overflow, so the sign of A alone decides.
  assign lt    = (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]) ? a_reg[DATA_W-1] : diff[DATA_W-1];
  assign taken = (is_beq && (diff == '0)) || (is_bne && (diff != '0));

  always_comb begin
    alu_res = a_reg + alu_b;
    case (op)
      4'd0:  alu_res = a_reg + b_reg;
      4'd1:  alu_res = diff;
      4'd2:  alu_res = a_reg & b_reg;
      4'd3:  alu_res = a_reg | b_reg;
      4'd4:  alu_res = ~(a_reg | b_reg);
      4'd5:  alu_res = ~(a_reg & b_reg);
      4'd6:  alu_res = {{(DATA_W-1){1'b0}}, lt};
      4'd7:  alu_res = a_reg + imm_d;
      4'd10,
      4'd11: alu_res = diff;
      default: alu_res = a_reg + alu_b;  // NOP: result is never written
    endcase
  end

  // FSM state register. The request flag is part of the control state so
  // that the first post-reset FETCH cycle has req=0 and the request rises
  // one cycle after reset release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_FETCH;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    case (state_reg)
      ST_FETCH: begin
        if (!req_reg) begin
          req_next = 1'b1;
        end else if (imem.ack) begin
          req_next   = 1'b0;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE:    state_next = (ir_reg == HALT_WORD) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   state_next = ST_WRITEBACK;
      ST_WRITEBACK: begin
        state_next = ST_FETCH;
        req_next   = 1'b1;
      end
      ST_HALT:      state_next = ST_HALT;
      default: begin
        state_next = ST_FETCH;
        req_next   = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_reg   <= '0;
      taken_reg <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state_reg)
        ST_FETCH: if (req_reg && imem.ack) ir_reg <= imem.rdata;
        ST_DECODE: begin
          a_reg <= regs[rs];
          b_reg <= regs[rt];
        end
        ST_EXECUTE: begin
          alu_reg   <= alu_res;
          taken_reg <= taken;
        end
        ST_WRITEBACK: begin
          // R0 is never written, so it always reads as zero.
          if (writes_reg && (dest != 2'd0)) regs[dest] <= alu_reg;
          pc_reg <= taken_reg ? br_target : pc_plus2;
        end
        default: ;
      endcase
    end
  end

  assign imem.req  = req_reg;
  assign imem.addr = pc_reg;
  assign pc        = pc_reg;
  assign ir        = ir_reg;
  assign alu_out   = alu_reg;
  assign state     = state_reg;
  assign retire    = (state_reg == ST_WRITEBACK);
  assign halted    = (state_reg == ST_HALT);

endmodule
